fmul_pipe: RTL and testbench

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fmul_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_pipe
//  Description : Three-stage IEEE-style floating-point multiplier with
//                valid/ready handshake, rounding modes and exception flags.
//  Revision    : 1.0  initial release
// ============================================================================
module fmul_pipe #(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 23,
    parameter  int TAG_W  = 4,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [1:0]        rmode,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic [TAG_W-1:0]  tag_out
);

    localparam int                      c_PROD_W     = 2 * (MAN_W + 1);
    localparam int                      c_XW         = EXP_W + 2;
    localparam logic [EXP_W-1:0]        c_EXP_ONES   = '1;
    localparam logic [EXP_W-1:0]        c_EXP_MAXFIN = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic signed [c_XW-1:0]  c_BIAS       = c_XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_XW-1:0]  c_XEXP_ONES  = c_XW'((1 << EXP_W) - 1);
    localparam logic signed [c_XW-1:0]  c_XEXP_MIN   = c_XW'(1);
    localparam logic [DATA_W-1:0]       c_QNAN       = {1'b0, c_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [3:0]              c_FLAG_INV   = 4'b1000;
    localparam logic [3:0]              c_FLAG_OVF   = 4'b0101;
    localparam logic [3:0]              c_FLAG_UNF   = 4'b0011;

    logic w_en;

    // ---------------- S1: unpack and special-case decode ----------------
    logic [EXP_W-1:0]  w_a_exp, w_b_exp;
    logic [MAN_W-1:0]  w_a_man, w_b_man;
    logic              w_a_nan, w_a_snan, w_a_inf, w_a_zero;
    logic              w_b_nan, w_b_snan, w_b_inf, w_b_zero;
    logic              w_sign;
    logic              w_special;
    logic [DATA_W-1:0] w_spec_res;
    logic [3:0]        w_spec_flags;

    assign w_a_exp = op1[DATA_W-2:MAN_W];
    assign w_b_exp = op2[DATA_W-2:MAN_W];
    assign w_a_man = op1[MAN_W-1:0];
    assign w_b_man = op2[MAN_W-1:0];
    assign w_sign  = op1[DATA_W-1] ^ op2[DATA_W-1];

    // Subnormal inputs collapse into the zero class.
    assign w_a_nan  = (w_a_exp == c_EXP_ONES) && (w_a_man != '0);
    assign w_a_snan = w_a_nan && !w_a_man[MAN_W-1];
    assign w_a_inf  = (w_a_exp == c_EXP_ONES) && (w_a_man == '0);
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_nan  = (w_b_exp == c_EXP_ONES) && (w_b_man != '0);
    assign w_b_snan = w_b_nan && !w_b_man[MAN_W-1];
    assign w_b_inf  = (w_b_exp == c_EXP_ONES) && (w_b_man == '0);
    assign w_b_zero = (w_b_exp == '0);

    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = '0;
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_res   = c_QNAN;
            w_spec_flags = (w_a_snan || w_b_snan) ? c_FLAG_INV : 4'b0000;
        end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_spec_res   = c_QNAN;
            w_spec_flags = c_FLAG_INV;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_res   = {w_sign, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_a_zero || w_b_zero) begin
            w_spec_res   = {w_sign, {(DATA_W-1){1'b0}}};
        end else begin
            w_special    = 1'b0;
        end
    end

    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [EXP_W-1:0]  r_s1_exp_a, r_s1_exp_b;
    logic [MAN_W:0]    r_s1_man_a, r_s1_man_b;
    logic              r_s1_special;
    logic [DATA_W-1:0] r_s1_spec_res;
    logic [3:0]        r_s1_spec_flags;
    logic [1:0]        r_s1_rmode;
    logic [TAG_W-1:0]  r_s1_tag;

    // ---------------- S2: mantissa multiply, exponent add ----------------
    logic [c_PROD_W-1:0]    w_prod;
    logic signed [c_XW-1:0] w_exp_sum;

    assign w_prod    = {{(MAN_W+1){1'b0}}, r_s1_man_a} * {{(MAN_W+1){1'b0}}, r_s1_man_b};
    assign w_exp_sum = $signed({2'b00, r_s1_exp_a}) + $signed({2'b00, r_s1_exp_b}) - c_BIAS;

    logic                   r_s2_valid;
    logic                   r_s2_sign;
    logic [c_PROD_W-1:0]    r_s2_prod;
    logic signed [c_XW-1:0] r_s2_exp;
    logic                   r_s2_special;
    logic [DATA_W-1:0]      r_s2_spec_res;
    logic [3:0]             r_s2_spec_flags;
    logic [1:0]             r_s2_rmode;
    logic [TAG_W-1:0]       r_s2_tag;

    // ---------------- S3: normalize, round, pack ----------------
    logic                   w_norm;
    logic [c_PROD_W-2:0]    w_frac;
    logic [MAN_W-1:0]       w_mant;
    logic                   w_guard, w_sticky, w_inexact, w_round_up, w_to_inf;
    logic [MAN_W:0]         w_mant_rnd;
    logic signed [c_XW-1:0] w_exp_rnd;
    logic                   w_ovf, w_unf;
    logic [DATA_W-1:0]      w_res;
    logic [3:0]             w_flags;

    // Fraction aligned so the hidden bit sits just above w_frac.
    assign w_norm     = r_s2_prod[c_PROD_W-1];
    assign w_frac     = w_norm ? r_s2_prod[c_PROD_W-2:0] : {r_s2_prod[c_PROD_W-3:0], 1'b0};
    assign w_mant     = w_frac[c_PROD_W-2 -: MAN_W];
    assign w_guard    = w_frac[MAN_W];
    assign w_sticky   = |w_frac[MAN_W-1:0];
    assign w_inexact  = w_guard | w_sticky;

    always_comb begin
        w_round_up = 1'b0;
        w_to_inf   = 1'b0;
        case (r_s2_rmode)
            2'd0: begin
                w_round_up = w_guard & (w_sticky | w_mant[0]);
                w_to_inf   = 1'b1;
            end
            2'd1: begin
                w_round_up = 1'b0;
                w_to_inf   = 1'b0;
            end
            2'd2: begin
                w_round_up = w_inexact & ~r_s2_sign;
                w_to_inf   = ~r_s2_sign;
            end
            default: begin
                w_round_up = w_inexact & r_s2_sign;
                w_to_inf   = r_s2_sign;
            end
        endcase
    end

    assign w_mant_rnd = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_round_up};
    assign w_exp_rnd  = r_s2_exp
                      + $signed({{(c_XW-1){1'b0}}, w_norm})
                      + $signed({{(c_XW-1){1'b0}}, w_mant_rnd[MAN_W]});
    assign w_ovf      = (w_exp_rnd >= c_XEXP_ONES);
    assign w_unf      = (w_exp_rnd <  c_XEXP_MIN);

    always_comb begin
        w_res   = {r_s2_sign, w_exp_rnd[EXP_W-1:0], w_mant_rnd[MAN_W-1:0]};
        w_flags = {3'b000, w_inexact};
        if (r_s2_special) begin
            w_res   = r_s2_spec_res;
            w_flags = r_s2_spec_flags;
        end else if (w_ovf) begin
            w_flags = c_FLAG_OVF;
            w_res   = w_to_inf ? {r_s2_sign, c_EXP_ONES, {MAN_W{1'b0}}}
                               : {r_s2_sign, c_EXP_MAXFIN, {MAN_W{1'b1}}};
        end else if (w_unf) begin
            w_flags = c_FLAG_UNF;
            w_res   = {r_s2_sign, {(DATA_W-1){1'b0}}};
        end
    end

    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;
    logic [TAG_W-1:0]  r_tag_out;

    // One enable for every stage: the whole pipe freezes while the output stalls.
    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign tag_out   = r_tag_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_tag_out   <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            r_result    <= w_res;
            r_flags     <= w_flags;
            r_tag_out   <= r_s2_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_sign       <= w_sign;
            r_s1_exp_a      <= w_a_exp;
            r_s1_exp_b      <= w_b_exp;
            r_s1_man_a      <= {1'b1, w_a_man};
            r_s1_man_b      <= {1'b1, w_b_man};
            r_s1_special    <= w_special;
            r_s1_spec_res   <= w_spec_res;
            r_s1_spec_flags <= w_spec_flags;
            r_s1_rmode      <= rmode;
            r_s1_tag        <= tag_in;

            r_s2_sign       <= r_s1_sign;
            r_s2_prod       <= w_prod;
            r_s2_exp        <= w_exp_sum;
            r_s2_special    <= r_s1_special;
            r_s2_spec_res   <= r_s1_spec_res;
            r_s2_spec_flags <= r_s1_spec_flags;
            r_s2_rmode      <= r_s1_rmode;
            r_s2_tag        <= r_s1_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_pipe
//  Description : Self-checking bench for fmul_pipe with a reference model
//                and in-order scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fmul_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op1, op2, result;
    logic [1:0]  rmode;
    logic [3:0]  tag_in, tag_out, flags;

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .rmode     (rmode),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
        logic [3:0]  tag;
    } exp_t;

    // Reference product from integer arithmetic on the real-valued significands.
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] rm, input logic [3:0] tg);
        exp_t      r;
        int        ea, eb, e, sh;
        bit [63:0] p, q, rem, half;
        logic      sgn, up, to_inf;
        logic      nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sgn    = a[31] ^ b[31];
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        snan_a = nan_a && !a[22];
        snan_b = nan_b && !b[22];
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        r.tag  = tg;
        if (nan_a || nan_b) begin
            r.res = 32'h7FC00000;
            r.fl  = (snan_a || snan_b) ? 4'b1000 : 4'b0000;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            r.res = 32'h7FC00000;
            r.fl  = 4'b1000;
        end else if (inf_a || inf_b) begin
            r.res = {sgn, 31'h7F800000};
            r.fl  = 4'b0000;
        end else if (zero_a || zero_b) begin
            r.res = {sgn, 31'h0};
            r.fl  = 4'b0000;
        end else begin
            p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            e  = ea + eb - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            case (rm)
                2'd0:    up = (rem > half) || ((rem == half) && q[0]);
                2'd1:    up = 1'b0;
                2'd2:    up = (rem != 0) && !sgn;
                default: up = (rem != 0) && sgn;
            endcase
            q = q + 64'(up);
            if (q >= (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                to_inf = (rm == 2'd0) || (rm == 2'd2 && !sgn) || (rm == 2'd3 && sgn);
                r.res  = to_inf ? {sgn, 31'h7F800000} : {sgn, 31'h7F7FFFFF};
                r.fl   = 4'b0101;
            end else if (e < 1) begin
                r.res = {sgn, 31'h0};
                r.fl  = 4'b0011;
            end else begin
                r.res = {sgn, 8'(e), q[22:0]};
                r.fl  = {3'b000, rem != 0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6) v[30:23] = 8'($urandom_range(90, 165));
        else if (k == 6) v[30:23] = 8'($urandom_range(1, 254));
        else if (k == 7) begin
            case ($urandom_range(0, 8))
                0:       v = 32'h00000000;
                1:       v = 32'h80000000;
                2:       v = 32'h7F800000;
                3:       v = 32'hFF800000;
                4:       v = 32'h7FC00001;
                5:       v = 32'h7F800001;
                6:       v = 32'h00000123;
                7:       v = 32'h7F7FFFFF;
                default: v = 32'h00800000;
            endcase
        end
        return v;
    endfunction

    // Scoreboard and output-side monitor, sampled on the falling edge.
    exp_t        sb[$];
    exp_t        sb_head;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [3:0]  prev_fl, prev_tag;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check("hold_valid",  32'(out_valid), 32'd1);
                check("hold_result", result,         prev_res);
                check("hold_flags",  32'(flags),     32'(prev_fl));
                check("hold_tag",    32'(tag_out),   32'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    sb_head = sb.pop_front();
                    check("sb_result", result,       sb_head.res);
                    check("sb_flags",  32'(flags),   32'(sb_head.fl));
                    check("sb_tag",    32'(tag_out), 32'(sb_head.tag));
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_mul(op1, op2, rmode, tag_in));
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_fl    = flags;
            prev_tag   = tag_out;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [3:0] tg);
        int n;
        op1 = a; op2 = b; rmode = rm; tag_in = tg; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm, input logic [3:0] tg,
                           input logic [31:0] er, input logic [3:0] ef);
        int lat;
        send(a, b, rm, tg);
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat),     32'd3);
        check({name, "_result"},  result,       er);
        check({name, "_flags"},   32'(flags),   32'(ef));
        check({name, "_tag"},     32'(tag_out), 32'(tg));
        @(posedge clk);
        #1;
    endtask

    logic rnd_done;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; rmode = '0; tag_in = '0;
        rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_tag",       32'(tag_out),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        run_one("two_x_three",  32'h40000000, 32'h40400000, 2'd0, 4'd5,  32'h40C00000, 4'b0000);
        run_one("inf_x_zero",   32'h7F800000, 32'h00000000, 2'd0, 4'd1,  32'h7FC00000, 4'b1000);
        run_one("ninf_x_one",   32'hFF800000, 32'h3F800000, 2'd0, 4'd2,  32'hFF800000, 4'b0000);
        run_one("ovf_rne",      32'h7F7FFFFF, 32'h40000000, 2'd0, 4'd3,  32'h7F800000, 4'b0101);
        run_one("ovf_rtz",      32'h7F7FFFFF, 32'h40000000, 2'd1, 4'd4,  32'h7F7FFFFF, 4'b0101);
        run_one("novf_rup",     32'hFF7FFFFF, 32'h40000000, 2'd2, 4'd6,  32'hFF7FFFFF, 4'b0101);
        run_one("novf_rdn",     32'hFF7FFFFF, 32'h40000000, 2'd3, 4'd7,  32'hFF800000, 4'b0101);
        run_one("underflow",    32'h00800000, 32'h3F000000, 2'd0, 4'd8,  32'h00000000, 4'b0011);
        run_one("inexact_rtz",  32'h3F800001, 32'h3F800001, 2'd1, 4'd9,  32'h3F800002, 4'b0001);
        run_one("inexact_rup",  32'h3F800001, 32'h3F800001, 2'd2, 4'd10, 32'h3F800003, 4'b0001);
        run_one("snan_in",      32'h7F800001, 32'h3F800000, 2'd0, 4'd11, 32'h7FC00000, 4'b1000);
        run_one("qnan_in",      32'h7FC00001, 32'h3F800000, 2'd0, 4'd12, 32'h7FC00000, 4'b0000);
        run_one("subnorm_zero", 32'h00000123, 32'h40000000, 2'd0, 4'd13, 32'h00000000, 4'b0000);
        run_one("neg_zero",     32'h80000000, 32'h3F800000, 2'd0, 4'd14, 32'h80000000, 4'b0000);

        // Back-to-back burst with the consumer stalled for five cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 4'(i));
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check("stall_first_valid", 32'(out_valid), 32'd1);
                check("stall_in_ready",    32'(in_ready),  32'd0);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("drain_consecutive", 32'(out_valid), 32'd1);
                end
            end
        join
        @(posedge clk);
        #1;

        // Reset with two operations in flight and a third presented during reset.
        send(32'h40000000, 32'h40400000, 2'd0, 4'd1);
        send(32'h3F800000, 32'h40800000, 2'd0, 4'd2);
        reset = 1'b1;
        op1 = 32'h40400000; op2 = 32'h40400000; tag_in = 4'd3;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready",  32'(in_ready),  32'd1);
        check("flush_result",    result,         32'd0);
        check("flush_tag",       32'(tag_out),   32'd0);
        @(posedge clk);
        #1;
        run_one("post_reset", 32'h40800000, 32'h40000000, 2'd0, 4'd15, 32'h41000000, 4'b0000);
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic with input bubbles and output back-pressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 4'($urandom));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
